// File: rtl/qoa_slice_sequencer_if.sv
// qoa_slice_sequencer_if
// Handshake bundle between a slice producer / residual consumer and the
// QOA slice sequencer.
//   in_valid/in_ready/slice_in : 64-bit QOA slice into the sequencer
//   deq_valid/deq_ready        : dequantised residual handshake out
//   deq_data                   : signed 16-bit dequantised residual
//   deq_idx                    : residual index 0..19 within the slice
//   deq_last/frame_last        : last residual of slice / of frame
// The master modport is the surrounding system; the slave modport is the
// sequencer itself.
interface qoa_slice_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] slice_in;
  logic        deq_valid;
  logic        deq_ready;
  logic [15:0] deq_data;
  logic [4:0]  deq_idx;
  logic        deq_last;
  logic        frame_last;

  modport master (
    output in_valid, slice_in, deq_ready,
    input  in_ready, deq_valid, deq_data, deq_idx, deq_last, frame_last
  );

  modport slave (
    input  in_valid, slice_in, deq_ready,
    output in_ready, deq_valid, deq_data, deq_idx, deq_last, frame_last
  );
endinterface

// File: rtl/qoa_slice_sequencer.sv
// qoa_slice_sequencer
// Accepts one 64-bit QOA slice at a time, latches its scale-factor index and
// walks its 20 packed 3-bit residuals through the QOA dequantisation table,
// emitting one registered 16-bit signed value per downstream handshake.
// Counts completed slices per frame and flags the last residual of each
// slice and of each frame.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous abort, drops the slice and clears slice_cnt
//   bus         : slave side of qoa_slice_sequencer_if (slice in, residuals out)
//   slice_cnt   : slices fully emitted in the current frame
//   busy        : a slice is being emitted
module qoa_slice_sequencer #(
  parameter int SLICES_PER_FRAME = 256,
  parameter int CNT_W            = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  qoa_slice_sequencer_if.slave bus,
  output logic [CNT_W-1:0]     slice_cnt,
  output logic                 busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES_PER_FRAME - 1);

  state_t      state, state_nxt;
  logic [3:0]  sf, sf_nxt;
  logic [56:0] shift, shift_nxt;
  logic [15:0] data, data_nxt;
  logic [4:0]  idx, idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  logic valid, last, beat, ready, accept;

  // Dequantisation table: each row holds the magnitudes for the even codes
  // 0,2,4,6; the following odd code is the negation of its even neighbour.
  function automatic logic [15:0] dequant(input logic [3:0] s, input logic [2:0] code);
    logic [55:0] row;
    logic [13:0] mag;
    case (s)
      4'd0:  row = {14'd1,    14'd3,    14'd5,    14'd7};
      4'd1:  row = {14'd5,    14'd18,   14'd32,   14'd49};
      4'd2:  row = {14'd16,   14'd53,   14'd95,   14'd147};
      4'd3:  row = {14'd34,   14'd113,  14'd203,  14'd315};
      4'd4:  row = {14'd63,   14'd210,  14'd378,  14'd588};
      4'd5:  row = {14'd104,  14'd345,  14'd621,  14'd966};
      4'd6:  row = {14'd158,  14'd528,  14'd950,  14'd1477};
      4'd7:  row = {14'd228,  14'd760,  14'd1368, 14'd2128};
      4'd8:  row = {14'd316,  14'd1053, 14'd1895, 14'd2947};
      4'd9:  row = {14'd422,  14'd1405, 14'd2529, 14'd3934};
      4'd10: row = {14'd548,  14'd1828, 14'd3290, 14'd5117};
      4'd11: row = {14'd696,  14'd2320, 14'd4176, 14'd6496};
      4'd12: row = {14'd868,  14'd2893, 14'd5207, 14'd8099};
      4'd13: row = {14'd1064, 14'd3548, 14'd6386, 14'd9933};
      4'd14: row = {14'd1286, 14'd4288, 14'd7718, 14'd12005};
      default: row = {14'd1536, 14'd5120, 14'd9216, 14'd14336};
    endcase
    case (code[2:1])
      2'd0:    mag = row[55:42];
      2'd1:    mag = row[41:28];
      2'd2:    mag = row[27:14];
      default: mag = row[13:0];
    endcase
    dequant = code[0] ? -{2'b00, mag} : {2'b00, mag};
  endfunction

  // Handshake decode. A new slice may be taken on the same edge that retires
  // residual 19, so back-to-back slices run without a bubble.
  always_comb begin
    valid  = (state == RUN);
    last   = valid && (idx == 5'd19);
    beat   = valid && bus.deq_ready;
    ready  = !flush && ((state == IDLE) || (beat && last));
    accept = bus.in_valid && ready;
  end

  assign bus.in_ready   = ready;
  assign bus.deq_valid  = valid;
  assign bus.deq_data   = data;
  assign bus.deq_idx    = idx;
  assign bus.deq_last   = last;
  assign bus.frame_last = last && (slice_cnt == CNT_LAST);
  assign busy           = (state == RUN);

  // Next-state and datapath update. Flush wins over everything and discards
  // any handshake in the same cycle; a beat on residual 19 completes the
  // slice and may be overridden by a same-edge accept.
  always_comb begin
    state_nxt = state;
    sf_nxt    = sf;
    shift_nxt = shift;
    data_nxt  = data;
    idx_nxt   = idx;
    cnt_nxt   = slice_cnt;
    if (flush) begin
      state_nxt = IDLE;
      idx_nxt   = 5'd0;
      cnt_nxt   = '0;
    end else begin
      if (beat) begin
        if (last) begin
          cnt_nxt   = (slice_cnt == CNT_LAST) ? '0 : slice_cnt + CNT_W'(1);
          state_nxt = IDLE;
        end else begin
          data_nxt  = dequant(sf, shift[56:54]);
          shift_nxt = {shift[53:0], 3'b000};
          idx_nxt   = idx + 5'd1;
        end
      end
      if (accept) begin
        sf_nxt    = bus.slice_in[63:60];
        shift_nxt = bus.slice_in[56:0];
        data_nxt  = dequant(bus.slice_in[63:60], bus.slice_in[59:57]);
        idx_nxt   = 5'd0;
        state_nxt = RUN;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sf        <= 4'd0;
      shift     <= '0;
      data      <= 16'd0;
      idx       <= 5'd0;
      slice_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sf        <= sf_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      idx       <= idx_nxt;
      slice_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_qoa_slice_sequencer.sv
// tb_qoa_slice_sequencer
// Self-checking bench for qoa_slice_sequencer. Expected residuals come from
// the QOA scale-factor table and the rounding rule round(sf * {0.75, 2.5,
// 4.5, 7}); table vectors carry hand-computed first/last residuals.
`timescale 1ns/100ps
module tb_qoa_slice_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       flush2;
  logic [7:0] slice_cnt;
  logic       busy;
  logic [1:0] slice_cnt2;
  logic       busy2;

  qoa_slice_sequencer_if bus ();
  qoa_slice_sequencer_if bus2 ();

  qoa_slice_sequencer #(.SLICES_PER_FRAME(256), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .slice_cnt (slice_cnt),
    .busy      (busy)
  );

  qoa_slice_sequencer #(.SLICES_PER_FRAME(2), .CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush2),
    .bus       (bus2),
    .slice_cnt (slice_cnt2),
    .busy      (busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  int sft_tab [16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419, 1715, 2048};
  int k4_tab  [4]  = '{3, 10, 18, 28};

  typedef struct {
    logic [63:0] slice;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;

  vec_t vecs [9];

  // Reference dequantiser: quarter-step multipliers with round-half-up.
  function automatic logic [15:0] model(input logic [63:0] s, input int k);
    logic [2:0] code;
    int mag;
    code = s[59 - 3*k -: 3];
    mag  = (sft_tab[s[63:60]] * k4_tab[code[2:1]] + 2) / 4;
    return code[0] ? 16'(-mag) : 16'(mag);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [63:0] s, input logic r, input logic f);
    bus.in_valid  = v;
    bus.slice_in  = s;
    bus.deq_ready = r;
    flush         = f;
    #1;
  endtask

  // Accepts one slice from IDLE and drains it with deq_ready held high,
  // checking every residual against the model.
  task automatic run_slice(input logic [63:0] s, output logic [15:0] first, output logic [15:0] lastv);
    apply_stimulus(1'b1, s, 1'b1, 1'b0);
    check_output("idle_in_ready", bus.in_ready, 1);
    step();
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b0);
    first = bus.deq_data;
    lastv = 16'd0;
    for (int k = 0; k < 20; k++) begin
      check_output("run_valid", bus.deq_valid, 1);
      check_output("run_idx", bus.deq_idx, k);
      check_output("run_data", bus.deq_data, model(s, k));
      check_output("run_last", bus.deq_last, (k == 19));
      if (k == 19) begin
        lastv = bus.deq_data;
        check_output("run_frame_last", bus.frame_last, (exp_cnt == 255));
        exp_cnt = (exp_cnt + 1) % 256;
      end
      step();
    end
    check_output("done_busy", busy, 0);
    check_output("done_valid", bus.deq_valid, 0);
    check_output("done_cnt", slice_cnt, exp_cnt);
  endtask

  initial begin
    logic [15:0] f, l;
    logic [63:0] s, a, b, x;
    int beat;

    vecs[0] = '{64'hF000_0000_0000_0007,   16'h0600, 16'hC800};
    vecs[1] = '{{4'h3, 3'd2, 3'd3, 54'd0}, 16'h0071, 16'h0022};
    vecs[2] = '{{4'h0, 3'd1, 54'd0, 3'd6}, 16'hFFFF, 16'h0007};
    vecs[3] = '{{4'h7, 3'd4, 54'd0, 3'd5}, 16'h0558, 16'hFAA8};
    vecs[4] = '{{4'hD, 3'd6, 54'd0, 3'd3}, 16'h26CD, 16'hF224};
    vecs[5] = '{{4'hA, 3'd7, 54'd0, 3'd2}, 16'hEC03, 16'h0724};
    vecs[6] = '{{4'h1, 3'd2, 54'd0, 3'd4}, 16'h0012, 16'h0020};
    vecs[7] = '{{4'hE, 3'd5, 54'd0, 3'd0}, 16'hE1DA, 16'h0506};
    vecs[8] = '{64'hC123_4567_89AB_CDEF,   16'h0364, 16'hE05D};

    rst_n          = 1'b0;
    flush2         = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.slice_in  = 64'd0;
    bus2.deq_ready = 1'b1;
    apply_stimulus(1'b0, 64'd0, 1'b0, 1'b0);
    #11;
    check_output("rst_valid", bus.deq_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_idx", bus.deq_idx, 0);
    check_output("rst_data", bus.deq_data, 0);
    check_output("rst_last", bus.deq_last, 0);
    check_output("rst_frame_last", bus.frame_last, 0);
    check_output("rst_cnt", slice_cnt, 0);
    rst_n = 1'b1;
    step();

    // Table-driven single slices.
    for (int i = 0; i < 9; i++) begin
      run_slice(vecs[i].slice, f, l);
      check_output("vec_first", f, vecs[i].first);
      check_output("vec_last", l, vecs[i].last);
    end

    // Backpressure: deq_ready toggles, outputs must hold while stalled.
    s = {4'h3, 3'd2, 3'd3, 54'd0};
    apply_stimulus(1'b1, s, 1'b0, 1'b0);
    step();
    beat = 0;
    for (int cyc = 0; cyc < 60 && beat < 20; cyc++) begin
      apply_stimulus(1'b0, 64'd0, (cyc % 2 == 0), 1'b0);
      check_output("bp_valid", bus.deq_valid, 1);
      check_output("bp_idx", bus.deq_idx, beat);
      check_output("bp_data", bus.deq_data, model(s, beat));
      if (beat == 0) check_output("bp_r0", bus.deq_data, 16'h0071);
      if (beat == 1) check_output("bp_r1", bus.deq_data, 16'hFF8F);
      if (beat > 1)  check_output("bp_rn", bus.deq_data, 16'h0022);
      if (bus.deq_ready) beat++;
      step();
    end
    check_output("bp_beats", beat, 20);
    exp_cnt++;
    check_output("bp_cnt", slice_cnt, exp_cnt);

    // Back-to-back slices with in_valid held.
    a = 64'hF000_0000_0000_0007;
    b = {4'h7, 3'd4, 54'd0, 3'd5};
    apply_stimulus(1'b1, a, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b1, b, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      check_output("b2b_a_idx", bus.deq_idx, k);
      check_output("b2b_a_data", bus.deq_data, model(a, k));
      check_output("b2b_in_ready", bus.in_ready, (k == 19));
      step();
    end
    exp_cnt++;
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b0);
    check_output("b2b_b_first", bus.deq_data, 16'h0558);
    for (int k = 0; k < 20; k++) begin
      check_output("b2b_b_valid", bus.deq_valid, 1);
      check_output("b2b_b_idx", bus.deq_idx, k);
      check_output("b2b_b_data", bus.deq_data, model(b, k));
      step();
    end
    exp_cnt++;
    check_output("b2b_cnt", slice_cnt, exp_cnt);
    check_output("b2b_busy", busy, 0);

    // Flush at residual 7 with a competing in_valid.
    s = vecs[8].slice;
    x = {4'h9, 3'd6, 57'd0};
    apply_stimulus(1'b1, s, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) step();
    check_output("fl_pre_idx", bus.deq_idx, 7);
    apply_stimulus(1'b1, x, 1'b1, 1'b1);
    check_output("fl_in_ready", bus.in_ready, 0);
    step();
    apply_stimulus(1'b1, x, 1'b1, 1'b0);
    exp_cnt = 0;
    check_output("fl_valid", bus.deq_valid, 0);
    check_output("fl_busy", busy, 0);
    check_output("fl_idx", bus.deq_idx, 0);
    check_output("fl_cnt", slice_cnt, 0);
    check_output("fl_ready_after", bus.in_ready, 1);
    step();
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b0);
    check_output("fl_acc_valid", bus.deq_valid, 1);
    check_output("fl_acc_idx", bus.deq_idx, 0);
    check_output("fl_acc_data", bus.deq_data, 16'h0F5E);
    for (int k = 0; k < 20; k++) step();
    exp_cnt = 1;
    check_output("fl_drain_busy", busy, 0);
    check_output("fl_drain_cnt", slice_cnt, exp_cnt);

    // Asynchronous reset in the middle of a slice.
    apply_stimulus(1'b1, vecs[3].slice, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step();
    #1;
    rst_n = 1'b0;
    #1;
    check_output("ar_valid", bus.deq_valid, 0);
    check_output("ar_busy", busy, 0);
    check_output("ar_idx", bus.deq_idx, 0);
    check_output("ar_cnt", slice_cnt, 0);
    check_output("ar_data", bus.deq_data, 0);
    rst_n = 1'b1;
    #1;
    check_output("ar_in_ready", bus.in_ready, 1);
    exp_cnt = 0;
    step();

    // Two-slice frame on the second instance: three slices.
    for (int sl = 0; sl < 3; sl++) begin
      bus2.in_valid  = 1'b1;
      bus2.slice_in  = vecs[sl].slice;
      bus2.deq_ready = 1'b1;
      #1;
      check_output("fr_cnt_start", slice_cnt2, sl % 2);
      step();
      bus2.in_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (k == 0)  check_output("fr_fl_first", bus2.frame_last, 0);
        if (k == 19) check_output("fr_fl_last", bus2.frame_last, (sl == 1));
        check_output("fr_data", bus2.deq_data, model(vecs[sl].slice, k));
        step();
      end
    end
    check_output("fr_cnt_end", slice_cnt2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
